// File: rtl/fa_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state
// encoding and the default operand width.
package fa_pkg;

    // Default operand/sum width and the legal range of widths.
    localparam int FA_DEFAULT_WIDTH = 8;
    localparam int FA_MIN_WIDTH     = 2;
    localparam int FA_MAX_WIDTH     = 32;

    // Controller states: waiting for a start, shifting bits, presenting the result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fa_state_e;

endpackage : fa_pkg

// File: rtl/fa_dataflow.sv
// Single-bit full-adder cell, purely combinational. The serial controller
// time-shares one instance of this cell across every bit of the addition.
module fa_dataflow (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum is the parity of the three inputs; carry is generate or propagate.
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule : fa_dataflow

// File: rtl/fa_serial_ctrl.sv
// Bit-serial adder controller. Latches two WIDTH-bit operands and a carry-in
// on an accepted start, feeds one bit per clock (LSB first) through a single
// fa_dataflow cell, and presents the assembled sum and carry-out with a
// one-cycle done pulse. Latency is WIDTH+1 cycles from start to done.
//
// Optional feature: define FA_SERIAL_OVF_EN to add the ovf port, which
// reports signed two's-complement overflow of the last addition.
module fa_serial_ctrl
    import fa_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef FA_SERIAL_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    // Reject widths the counter and shifters were not sized for.
    if (WIDTH < FA_MIN_WIDTH || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
        $error("fa_serial_ctrl: WIDTH must be in 2..32");
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    fa_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q,  a_sh_d;
    logic [WIDTH-1:0] b_sh_q,  b_sh_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             carry_q, carry_d;
    logic             co_q,    co_d;
`ifdef FA_SERIAL_OVF_EN
    logic             ovf_q,   ovf_d;
`endif

    logic accept;
    logic cell_s;
    logic cell_co;

    // ------------------------------------------------------------------
    // The shared bit slice: current LSBs plus the running carry.
    // ------------------------------------------------------------------
    fa_dataflow u_cell (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    // A start is taken whenever the controller is not mid-addition.
    assign accept = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    // Next-state, datapath update and decoded handshake outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path
        // leaves one unassigned; a missed branch would otherwise infer a latch.
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;
`ifdef FA_SERIAL_OVF_EN
        ovf_d   = ovf_q;
`endif
        ready   = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
            end

            ST_RUN: begin
                // One bit per cycle: new sum bit enters at the MSB so that
                // after WIDTH shifts bit 0 sits at position 0.
                sum_d   = {cell_s, sum_q[WIDTH-1:1]};
                carry_d = cell_co;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_DONE;
                    co_d    = cell_co;
`ifdef FA_SERIAL_OVF_EN
                    // Carry into the MSB differs from carry out of it exactly
                    // when the signed result does not fit.
                    ovf_d   = carry_q ^ cell_co;
`endif
                end
            end

            ST_DONE: begin
                ready   = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Loading a new operation overrides the hold/return behaviour above;
        // the previous result is discarded on the same edge.
        if (accept) begin
            state_d = ST_RUN;
            a_sh_d  = a;
            b_sh_d  = b;
            carry_d = ci;
            cnt_d   = '0;
            sum_d   = '0;
            co_d    = 1'b0;
`ifdef FA_SERIAL_OVF_EN
            ovf_d   = 1'b0;
`endif
        end
    end

    // Register update with synchronous active-low reset; reset aborts any
    // addition in progress and discards the partial result.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples its _d value from before the edge, independent of order.
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
`ifdef FA_SERIAL_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
`ifdef FA_SERIAL_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Registered result outputs
    // ------------------------------------------------------------------
    assign sum = sum_q;
    assign co  = co_q;
`ifdef FA_SERIAL_OVF_EN
    assign ovf = ovf_q;
`endif

endmodule : fa_serial_ctrl

// File: tb/tb_fa_serial_ctrl.sv
// Scoreboard bench for fa_serial_ctrl. Stimulus tracks acceptance with a
// cycle-phase model and pushes arithmetic expectations; a negedge monitor
// checks handshake, result, hold and clear behaviour every cycle.
module tb_fa_serial_ctrl;
    import fa_pkg::*;

    localparam int W       = FA_DEFAULT_WIDTH;
    localparam int TIMEOUT = 200000;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
        int           t;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         ready;
    logic         done;
    logic [W-1:0] sum;
    logic         co;
`ifdef FA_SERIAL_OVF_EN
    logic         ovf;
`endif

    // Phase model: 0 = idle, 1..W = running, W+1 = done cycle.
    int   p     = 0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [W-1:0] last_sum = '0;
    logic         last_co  = 1'b0;
    logic         last_ovf = 1'b0;

    fa_serial_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
        .ready (ready),
        .done  (done),
        .sum   (sum),
        .co    (co)
`ifdef FA_SERIAL_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(TIMEOUT);
        $display("FAIL timeout: got cycle %0d required finish", cyc);
        $fatal(1, "bench timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic: plain integer addition and signed range test.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv, input int t);
        exp_t    e;
        longint  u;
        longint  s;
        u = longint'(av) + longint'(bv) + longint'(cv);
        s = longint'($signed(av)) + longint'($signed(bv)) + longint'(cv);
        e.sum = W'(u);
        e.co  = (u >= (64'sd1 <<< W));
        e.ovf = (s > ((64'sd1 <<< (W - 1)) - 1)) || (s < -(64'sd1 <<< (W - 1)));
        e.t   = t;
        return e;
    endfunction

    // One clock of stimulus; updates the phase model for the coming edge.
    task automatic step(input logic s, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic rv);
        @(negedge clk);
        start = s;
        a     = av;
        b     = bv;
        ci    = cv;
        rst_n = rv;
        #1;
        if (!rv) begin
            p = 0;
            exp_q.delete();
            last_sum = '0;
            last_co  = 1'b0;
            last_ovf = 1'b0;
        end else if (s && (p == 0 || p == W + 1)) begin
            exp_q.push_back(model(av, bv, cv, cyc));
            p = 1;
        end else if (p >= 1 && p <= W) begin
            p++;
        end else begin
            p = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    endtask

    task automatic op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        step(1'b1, av, bv, cv, 1'b1);
        idle(W + 2);
    endtask

    // Monitor: compares DUT outputs against the phase model and scoreboard.
    always @(negedge clk) begin
        check("ready", ready, (p == 0 || p == W + 1));
        check("done", done, (p == W + 1));
        if (p == W + 1) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("sum", sum, mon_e.sum);
                check("co", co, mon_e.co);
`ifdef FA_SERIAL_OVF_EN
                check("ovf", ovf, mon_e.ovf);
`endif
                check("latency", cyc - mon_e.t, W + 1);
                last_sum = mon_e.sum;
                last_co  = mon_e.co;
                last_ovf = mon_e.ovf;
            end
        end else if (p == 0) begin
            check("hold_sum", sum, last_sum);
            check("hold_co", co, last_co);
`ifdef FA_SERIAL_OVF_EN
            check("hold_ovf", ovf, last_ovf);
`endif
        end else begin
            if (p == 1) check("clear_sum", sum, 0);
            check("run_co", co, 0);
`ifdef FA_SERIAL_OVF_EN
            check("run_ovf", ovf, 0);
`endif
        end
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        ci    = 1'b0;
        step(1'b0, '0, '0, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        idle(2);

        // Directed corner cases.
        op(W'('h00), W'('h00), 1'b0);
        op(W'('hFF), W'('h01), 1'b0);
        op(W'('hA5), W'('h5A), 1'b1);
        op(W'('h7F), W'('h01), 1'b0);
        op(W'('h80), W'('h80), 1'b0);

        // Start re-asserted mid-run must be ignored.
        step(1'b1, W'('h11), W'('h22), 1'b0, 1'b1);
        idle(3);
        repeat (3) step(1'b1, W'('hFF), W'('hFF), 1'b1, 1'b1);
        idle(W + 2);

        // Start held high: back-to-back operations.
        repeat (3 * (W + 1)) step(1'b1, W'('h03), W'('h04), 1'b0, 1'b1);
        idle(W + 2);

        // Reset in the middle of a run, then a clean operation.
        step(1'b1, W'('h5C), W'('h3B), 1'b0, 1'b1);
        idle(4);
        step(1'b0, '0, '0, 1'b0, 1'b0);
        idle(2);
        op(W'('h12), W'('h34), 1'b1);

        // Randomized traffic with random start density.
        repeat (400) step(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                          1'($urandom_range(0, 1)), 1'b1);
        idle(W + 3);

        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_fa_serial_ctrl
